// File: rtl/traffic_request_arbiter.sv
// Round-robin arbiter for emergency and jam traffic requests with hold and guard timing.
// Optional build macro ARB_EMG_PREEMPT_EN lets a pending emergency cut short a jam grant.
module traffic_request_arbiter #(
    parameter int unsigned EMG_HOLD  = 8,
    parameter int unsigned JAM_HOLD  = 20,
    parameter int unsigned GUARD_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] emg_req,
    input  logic [3:0] jam_req,
    input  logic [3:0] empty_req,
    output logic [3:0] Emergency,
    output logic [3:0] Jam,
    output logic [3:0] Empty,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        EMG_GRANT,
        JAM_GRANT,
        GUARD
    } state_t;

    localparam logic [4:0] EMG_LAST   = 5'(EMG_HOLD - 1);
    localparam logic [4:0] JAM_LAST   = 5'(JAM_HOLD - 1);
    localparam logic [4:0] GUARD_LAST = 5'(GUARD_CYC - 1);
    localparam logic [1:0] ROAD_EAST  = 2'd3;

`ifdef ARB_EMG_PREEMPT_EN
    localparam bit PREEMPT_EN = 1'b1;
`else
    localparam bit PREEMPT_EN = 1'b0;
`endif

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [3:0] emg_pend_q, emg_pend_d;
    logic [3:0] jam_pend_q, jam_pend_d;
    logic [1:0] emg_ptr_q, emg_ptr_d;
    logic [1:0] jam_ptr_q, jam_ptr_d;
    logic [3:0] emergency_q, emergency_d;
    logic [3:0] jam_q, jam_d;
    logic [3:0] empty_q, empty_d;
    logic [1:0] emg_pick;
    logic [1:0] jam_pick;

    // Search order is East(3), North(2), West(1), South(0): descending bit index, wrapping.
    function automatic logic [1:0] rr_pick(input logic [3:0] pend, input logic [1:0] start);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = start - 2'(i);
            if (!found && pend[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [3:0] road_bit(input logic [1:0] road);
        return 4'b0001 << road;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        emg_ptr_d   = emg_ptr_q;
        jam_ptr_d   = jam_ptr_q;
        emergency_d = emergency_q;
        jam_d       = jam_q;
        emg_pick    = rr_pick(emg_pend_q, emg_ptr_q);
        jam_pick    = rr_pick(jam_pend_q, jam_ptr_q);

        case (state_q)
            IDLE: begin
                if (|emg_pend_q) begin
                    state_d     = EMG_GRANT;
                    emergency_d = road_bit(emg_pick);
                    jam_d       = '0;
                    cnt_d       = '0;
                    emg_ptr_d   = emg_pick - 2'd1;
                end else if (|jam_pend_q) begin
                    state_d     = JAM_GRANT;
                    jam_d       = road_bit(jam_pick);
                    emergency_d = '0;
                    cnt_d       = '0;
                    jam_ptr_d   = jam_pick - 2'd1;
                end
            end
            EMG_GRANT: begin
                if (cnt_q == EMG_LAST) begin
                    state_d     = GUARD;
                    emergency_d = '0;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            JAM_GRANT: begin
                if (PREEMPT_EN && (|emg_pend_q)) begin
                    state_d     = EMG_GRANT;
                    emergency_d = road_bit(emg_pick);
                    jam_d       = '0;
                    cnt_d       = '0;
                    emg_ptr_d   = emg_pick - 2'd1;
                end else if (cnt_q == JAM_LAST) begin
                    state_d = GUARD;
                    jam_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                emergency_d = '0;
                jam_d       = '0;
            end
        endcase

        // Masking with the next grant both clears the served bit and ignores re-requests while held.
        emg_pend_d = (emg_pend_q | emg_req) & ~emergency_d;
        jam_pend_d = (jam_pend_q | jam_req) & ~jam_d;

        empty_d = '0;
        if ((state_q == IDLE) && !(|emg_pend_q) && !(|jam_pend_q) && $onehot(empty_req)) begin
            empty_d = empty_req;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            emg_pend_q  <= '0;
            jam_pend_q  <= '0;
            emg_ptr_q   <= ROAD_EAST;
            jam_ptr_q   <= ROAD_EAST;
            emergency_q <= '0;
            jam_q       <= '0;
            empty_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            emg_pend_q  <= emg_pend_d;
            jam_pend_q  <= jam_pend_d;
            emg_ptr_q   <= emg_ptr_d;
            jam_ptr_q   <= jam_ptr_d;
            emergency_q <= emergency_d;
            jam_q       <= jam_d;
            empty_q     <= empty_d;
        end
    end

    assign Emergency = emergency_q;
    assign Jam       = jam_q;
    assign Empty     = empty_q;
    assign busy      = (state_q != IDLE);

    // Output invariants for the light controller.
    a_excl : assert property (@(posedge clk) disable iff (!rst) !((|Emergency) && (|Jam)));
    a_one  : assert property (@(posedge clk) disable iff (!rst) $onehot0(Emergency) && $onehot0(Jam) && $onehot0(Empty));

endmodule
